// File: rtl/quant_scheduler.sv
// quant_scheduler: round-robin issue of Y/Cb/Cr 8x8 blocks onto one shared
// quantizer, with an in-order tag FIFO that routes each quantizer result back
// to its owning channel, plus a flush/drain path and a sticky error flag.
// Optional build macro: QSCHED_LUMA_PRIO_EN gives Y strict priority, and
// round-robin then applies between Cb and Cr only.
//
// state | meaning
// IDLE  | no work requested; nothing is issued
// RUN   | issuing at most one block per cycle while there is room in flight
// DRAIN | flush requested; no issue, waiting for every in-flight block
module quant_scheduler #(
    parameter int LATENCY      = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic       q_enable,
    output logic [1:0] tbl_sel,
    input  logic       q_out_valid,
    output logic [2:0] done,
    input  logic       flush,
    output logic       flush_done,
    output logic       busy,
    output logic       err
);

    localparam int PTR_W = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = PTR_W + 1;

    // LATENCY only documents the quantizer; the tag FIFO tolerates any latency.
    if (MAX_INFLIGHT < 2 || (MAX_INFLIGHT & (MAX_INFLIGHT - 1)) != 0 || LATENCY < 1) begin : g_bad_params
        $error("quant_scheduler: MAX_INFLIGHT must be a power of two >= 2 and LATENCY >= 1");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

    state_e           state_q, state_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]       tag_q [MAX_INFLIGHT];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    logic             win_vld;
    logic [1:0]       win_idx;
    logic             push, pop;
    logic [1:0]       head;

`ifdef QSCHED_LUMA_PRIO_EN
    // Y always wins; otherwise the pointer decides which chroma channel looks first.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        if (req[0]) begin
            win_vld = 1'b1;
            win_idx = 2'd0;
        end else if (rr_ptr_q == 2'd2) begin
            if (req[2]) begin
                win_vld = 1'b1;
                win_idx = 2'd2;
            end else if (req[1]) begin
                win_vld = 1'b1;
                win_idx = 2'd1;
            end
        end else begin
            if (req[1]) begin
                win_vld = 1'b1;
                win_idx = 2'd1;
            end else if (req[2]) begin
                win_vld = 1'b1;
                win_idx = 2'd2;
            end
        end
    end
`else
    logic [1:0] ord0, ord1, ord2;

    // Three-way round-robin: search pointer, pointer+1, pointer+2 (mod 3).
    always_comb begin
        ord0    = rr_ptr_q;
        ord1    = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
        ord2    = (rr_ptr_q == 2'd0) ? 2'd2 : rr_ptr_q - 2'd1;
        win_vld = 1'b0;
        win_idx = 2'd0;
        if (req[ord0]) begin
            win_vld = 1'b1;
            win_idx = ord0;
        end else if (req[ord1]) begin
            win_vld = 1'b1;
            win_idx = ord1;
        end else if (req[ord2]) begin
            win_vld = 1'b1;
            win_idx = ord2;
        end
    end
`endif

    // Issue/retire decisions, in-flight bookkeeping and FSM next state.
    always_comb begin
        pop  = q_out_valid && (cnt_q != '0);
        head = tag_q[rd_ptr_q];
        // A retiring block frees its slot in the same cycle, so a full FIFO can still accept.
        push = (state_q == ST_RUN) && !flush && win_vld &&
               ((cnt_q < CNT_W'(MAX_INFLIGHT)) || pop);

        grant    = push ? (3'b001 << win_idx) : 3'b000;
        q_enable = push;
        tbl_sel  = push ? win_idx : 2'd0;
        done     = pop ? (3'b001 << head) : 3'b000;

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        rr_ptr_d = rr_ptr_q;
        if (push) rr_ptr_d = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;

        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush)     state_d = ST_DRAIN;
                else if (|req) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush)                                 state_d = ST_DRAIN;
                else if (req == 3'b000 && cnt_q == '0)     state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                // Finishing in the cycle of the last retire makes flush_done coincide with its done.
                if (cnt_d == '0) begin
                    state_d    = ST_IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy = (cnt_q != '0);
        err  = err_q;
    end

    // State, pointers, tag storage and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 2'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_INFLIGHT; i++) tag_q[i] <= 2'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            if (q_out_valid && cnt_q == '0) err_q <= 1'b1;
            if (push) begin
                tag_q[wr_ptr_q] <= win_idx;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_quant_scheduler.sv
// Directed bench for quant_scheduler: steady round-robin issue against a
// fixed-latency quantizer model, back-pressure at MAX_INFLIGHT, flush/drain,
// spurious-valid error and mid-operation reset.
module tb_quant_scheduler;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] grant;
    logic       q_enable;
    logic [1:0] tbl_sel;
    logic       q_out_valid;
    logic [2:0] done;
    logic       flush = 1'b0;
    logic       flush_done;
    logic       busy;
    logic       err;

    logic       model_en = 1'b0;
    logic       qv_drv = 1'b0;
    logic [LAT-1:0] q_pipe = '0;

    int n_vec = 0;
    int n_err = 0;

    quant_scheduler #(.LATENCY(LAT), .MAX_INFLIGHT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .q_enable(q_enable),
        .tbl_sel(tbl_sel), .q_out_valid(q_out_valid), .done(done), .flush(flush),
        .flush_done(flush_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Fixed-latency quantizer: a valid comes back LAT cycles after each q_enable.
    always @(posedge clk) q_pipe <= {q_pipe[LAT-2:0], q_enable};
    assign q_out_valid = model_en ? q_pipe[LAT-1] : qv_drv;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] steady_grant(input int k);
`ifdef QSCHED_LUMA_PRIO_EN
        return 3'b001;
`else
        logic [2:0] seq [3];
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
        return seq[(k - 1) % 3];
`endif
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] g4 [3];
        // reset values
        #3;
        chk("rst_grant", grant, 3'b000);
        chk("rst_q_enable", q_enable, 1'b0);
        chk("rst_tbl_sel", tbl_sel, 2'd0);
        chk("rst_done", done, 3'b000);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // steady issue with all channels requesting
        model_en = 1'b1;
        cyc(); req = 3'b111; #1;
        chk("ss_idle_grant", grant, 3'b000);
        for (int k = 1; k <= 8; k++) begin
            cyc(); #1;
            chk("ss_grant", grant, steady_grant(k));
            chk("ss_q_enable", q_enable, 1'b1);
            chk("ss_tbl_sel", tbl_sel, (steady_grant(k) == 3'b001) ? 2'd0 :
                                       (steady_grant(k) == 3'b010) ? 2'd1 : 2'd2);
            chk("ss_done", done, (k < 5) ? 3'b000 : steady_grant(k - 4));
        end
        for (int k = 9; k <= 12; k++) begin
            cyc(); req = 3'b000; #1;
            chk("ss_tail_grant", grant, 3'b000);
            chk("ss_tail_done", done, steady_grant(k - 4));
        end
        cyc(); #1;
        chk("ss_busy_end", busy, 1'b0);
        model_en = 1'b0;
        cyc();

        // back-pressure at four in flight
        cyc(); req = 3'b001; #1;
        chk("bp_idle_grant", grant, 3'b000);
        for (int k = 1; k <= 4; k++) begin
            cyc(); #1;
            chk("bp_issue", grant, 3'b001);
        end
        for (int k = 5; k <= 6; k++) begin
            cyc(); #1;
            chk("bp_full_grant", grant, 3'b000);
            chk("bp_full_busy", busy, 1'b1);
        end
        cyc(); qv_drv = 1'b1; #1;
        chk("bp_pop_done", done, 3'b001);
        chk("bp_pop_issue", grant, 3'b001);
        cyc(); qv_drv = 1'b0; #1;
        chk("bp_refull_grant", grant, 3'b000);
        for (int k = 0; k < 4; k++) begin
            cyc(); req = 3'b000; qv_drv = 1'b1; #1;
            chk("bp_drain_done", done, 3'b001);
        end
        cyc(); qv_drv = 1'b0; #1;
        chk("bp_busy_end", busy, 1'b0);
        chk("bp_err", err, 1'b0);
        cyc();

        // flush with three blocks in flight (pointer now at Cb)
`ifdef QSCHED_LUMA_PRIO_EN
        g4[0] = 3'b001; g4[1] = 3'b001; g4[2] = 3'b001;
`else
        g4[0] = 3'b010; g4[1] = 3'b100; g4[2] = 3'b001;
`endif
        cyc(); req = 3'b111; #1;
        chk("fl_idle_grant", grant, 3'b000);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("fl_issue", grant, g4[k]);
        end
        cyc(); flush = 1'b1; #1;
        chk("fl_no_grant", grant, 3'b000);
        chk("fl_no_fdone", flush_done, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(); qv_drv = 1'b1; #1;
            chk("fl_done", done, g4[k]);
            chk("fl_grant", grant, 3'b000);
            chk("fl_fdone", flush_done, (k == 2) ? 1'b1 : 1'b0);
        end
        cyc(); qv_drv = 1'b0; flush = 1'b0; req = 3'b000; #1;
        chk("fl_fdone_once", flush_done, 1'b0);
        chk("fl_busy", busy, 1'b0);
        cyc(); flush = 1'b1; #1;
        chk("fl_idle_fdone0", flush_done, 1'b0);
        cyc(); flush = 1'b0; #1;
        chk("fl_idle_fdone1", flush_done, 1'b1);
        cyc(); #1;
        chk("fl_idle_fdone_end", flush_done, 1'b0);

        // spurious quantizer valid
        cyc(); qv_drv = 1'b1; #1;
        chk("sp_done", done, 3'b000);
        chk("sp_err_same", err, 1'b0);
        cyc(); qv_drv = 1'b0; #1;
        chk("sp_err_set", err, 1'b1);
        cyc(); cyc(); cyc(); #1;
        chk("sp_err_sticky", err, 1'b1);

        // reset clears err, then reset with two blocks in flight
        cyc(); rst_n = 1'b0; #1;
        chk("rr_err_clear", err, 1'b0);
        cyc(); rst_n = 1'b1;
        cyc(); req = 3'b001; #1;
        chk("rr_idle_grant", grant, 3'b000);
        cyc(); #1; chk("rr_issue1", grant, 3'b001);
        cyc(); #1; chk("rr_issue2", grant, 3'b001);
        cyc(); req = 3'b000; #1;
        chk("rr_busy_pre", busy, 1'b1);
        rst_n = 1'b0; qv_drv = 1'b1; req = 3'b001; #1;
        chk("rr_async_grant", grant, 3'b000);
        chk("rr_async_q_enable", q_enable, 1'b0);
        chk("rr_async_tbl_sel", tbl_sel, 2'd0);
        chk("rr_async_done", done, 3'b000);
        chk("rr_async_busy", busy, 1'b0);
        chk("rr_async_err", err, 1'b0);
        chk("rr_async_fdone", flush_done, 1'b0);
        cyc(); qv_drv = 1'b0; req = 3'b000;
        cyc(); rst_n = 1'b1;
        cyc(); qv_drv = 1'b1; #1;
        chk("rr_stale1_done", done, 3'b000);
        chk("rr_stale1_busy", busy, 1'b0);
        cyc(); qv_drv = 1'b0; #1;
        chk("rr_stale1_err", err, 1'b1);
        cyc(); qv_drv = 1'b1; #1;
        chk("rr_stale2_done", done, 3'b000);
        cyc(); qv_drv = 1'b0; #1;
        chk("rr_stale2_err", err, 1'b1);
        chk("rr_busy_end", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/quant_scheduler.md
QUANT_SCHEDULER -- requirements
Module: quant_scheduler

Interface
REQ-001 Parameter LATENCY, default 4: cycles from q_enable to matching q_out_valid of the shared quantizer.
REQ-002 Parameter MAX_INFLIGHT, default 4: tag FIFO depth and maximum outstanding blocks; power of two, at least 2.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req  in  3  block-ready request per channel; bit0=Y, bit1=Cb, bit2=Cr; held high until granted.
REQ-006 grant  out  3  one-hot, one-cycle acknowledge to the winning channel; the channel presents its 8x8 block this cycle.
REQ-007 q_enable  out  1  issue pulse to the shared quantizer, coincident with grant.
REQ-008 tbl_sel  out  2  quantization-table select for the issued block (0=luma, 1=Cb, 2=Cr), valid while q_enable=1.
REQ-009 q_out_valid  in  1  quantizer output-valid pulse, one cycle per issued block.
REQ-010 done  out  3  one-hot, one-cycle pulse to the channel owning the block currently on the quantizer output.
REQ-011 flush  in  1  level request to stop issuing and drain the pipeline.
REQ-012 flush_done  out  1  one-cycle pulse when a drain completes.
REQ-013 busy  out  1  high when inflight count is non-zero.
REQ-014 err  out  1  sticky error flag.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN.
REQ-016 IDLE->RUN when any req bit is high and flush=0.
REQ-017 RUN->DRAIN when flush=1.
REQ-018 RUN->IDLE when req=0 and inflight=0.
REQ-019 DRAIN->IDLE when inflight=0; flush_done pulses on that transition cycle.
REQ-020 Issue occurs in RUN only, at most one per cycle, only when inflight<MAX_INFLIGHT and flush=0.
REQ-021 Arbitration is round-robin: the pointer starts at Y and advances to the channel after the last granted one; search order is pointer, pointer+1, pointer+2 mod 3.
REQ-022 On issue: grant, q_enable and tbl_sel are driven in the same cycle, and the granted channel index is pushed into the tag FIFO.
REQ-023 On q_out_valid: the FIFO head is popped and done[head] pulses in the same cycle (combinational from the head).
REQ-024 Push and pop in the same cycle: the inflight count is unchanged and the tag order is preserved; a pop on a full FIFO permits a same-cycle push.
REQ-025 q_out_valid with an empty FIFO: err is set, no pop occurs, and done stays 0.
REQ-026 A block is not granted twice: after grant, the requesting channel drops req within one cycle; the scheduler does not retry.
REQ-027 flush asserted in IDLE: move to DRAIN, and flush_done pulses the next cycle because inflight=0.
REQ-028 inflight count is a log2(MAX_INFLIGHT)+1-bit counter; the tag FIFO pointers wrap modulo MAX_INFLIGHT.

Reset
REQ-029 While rst_n=0, the following take these values:
- grant, done, q_enable, flush_done, busy, err = 0
- tbl_sel = 0
- FSM = IDLE
- RR pointer = Y
- FIFO empty and inflight = 0
REQ-030 Reset mid-operation discards all outstanding tags; q_out_valid pulses after reset release for those tags set err.
REQ-031 err clears only on reset.

Configuration
REQ-032 Macro QSCHED_LUMA_PRIO_EN, when defined: Y has strict priority over Cb/Cr, and round-robin applies between Cb and Cr only.
REQ-033 Macro QSCHED_LUMA_PRIO_EN, when not defined: three-way round-robin as in REQ-021; all other behaviour is identical.

Verification
REQ-034 req=3'b111 held, quantizer model with LATENCY=4 -> grants Y,Cb,Cr,Y,... one per cycle; done order matches grant order 4 cycles later; with QSCHED_LUMA_PRIO_EN, grants are Y every cycle.
REQ-035 q_out_valid held low, req=3'b001 continuously re-asserted -> exactly 4 issues, then no grant while inflight=4; the first q_out_valid permits a same-cycle issue.
REQ-036 3 blocks in flight, flush=1 -> no further grants; flush_done pulses once in the cycle the third done pulses; FSM returns to IDLE.
REQ-037 q_out_valid pulse with nothing issued -> err=1 next cycle, done=0, and err remains 1 until rst_n low.
REQ-038 rst_n pulsed low with 2 blocks in flight -> all outputs 0 asynchronously; the two subsequent q_out_valid pulses set err; busy=0.
